v2i_slew_mc: RTL and testbench

Multi-channel, clocked successor to the combinational voltage-to-current model for the DAC top level. Each channel converts a real input voltage to a real output current, I = V/R, with voltage and current clamping. New in this block: a per-channel output slew-rate limit, a valid/ready capture handshake, per-channel enable, and saturation-fault detection with latch and clear. Sits between the DAC voltage stage and the current-output load model.

---
 rtl/v2i_slew_mc.sv | 176 +++++++++++++++++
 tb/tb_v2i_slew_mc.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/v2i_slew_mc.sv
// v2i_slew_mc: N_CH-channel voltage-to-current converter with V/I clamps, per-channel slew limit and sat-fault latch.
// Latency: capture at edge k, first iout step at edge k+1, settled after ceil(|target - iout| / I_STEP) edges.
// Backpressure: in_ready drops while any channel slews; in_valid is then ignored (no queue), so the source must hold it.
// Ports: clk/rst_n (async active-low) | vin[N_CH] real, in_valid/in_ready capture handshake | en, fault_clr per channel
//        iout[N_CH] real current | settled (IDLE and on target), sat (last capture clamped), fault (latched in FAULT)
module v2i_slew_mc #(
  parameter int  N_CH      = 4,
  parameter real R         = 1000.0,
  parameter real V_MIN     = -5.0,
  parameter real V_MAX     = 5.0,
  parameter real I_MIN     = -10.0e-3,
  parameter real I_MAX     = 10.0e-3,
  parameter real I_STEP    = 1.0e-4,
  parameter int  SAT_LIMIT = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  real             vin [N_CH],
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N_CH-1:0] en,
  input  logic [N_CH-1:0] fault_clr,
  output real             iout [N_CH],
  output logic [N_CH-1:0] settled,
  output logic [N_CH-1:0] sat,
  output logic [N_CH-1:0] fault
);

  typedef enum logic [1:0] {ST_OFF, ST_IDLE, ST_SLEW, ST_FAULT} state_t;

  localparam int CW = $clog2(SAT_LIMIT + 1);
  // A ramp of k whole steps accumulates a few ulps of error; the widened
  // window lets the last step land on target instead of leaving a tiny residue step.
  localparam real STEP_TOL = I_STEP * (1.0 + 1.0e-9);

  if (V_MIN > V_MAX || I_MIN > I_MAX) begin : g_cfg_err
    $error("v2i_slew_mc: clamp bounds inverted (V_MIN > V_MAX or I_MIN > I_MAX)");
  end

  state_t          state_q [N_CH];
  state_t          state_d [N_CH];
  real             iout_q  [N_CH];
  real             iout_d  [N_CH];
  real             tgt_q   [N_CH];
  real             tgt_d   [N_CH];
  logic [N_CH-1:0] sat_q, sat_d;
  logic [CW-1:0]   cnt_q   [N_CH];
  logic [CW-1:0]   cnt_d   [N_CH];

  real             vc_w    [N_CH];
  real             ic_w    [N_CH];
  real             cap_tgt [N_CH];
  real             diff_w  [N_CH];
  real             ramp_w  [N_CH];
  logic [CW-1:0]   cap_cnt [N_CH];
  logic [N_CH-1:0] cap_sat, cap_hit, ramp_done;
  logic            cap;

  assign cap = in_valid && in_ready;

  // Capture arithmetic and the next ramp point, per channel.
  always_comb begin
    cap_sat   = '0;
    cap_hit   = '0;
    ramp_done = '0;
    for (int c = 0; c < N_CH; c++) begin
      vc_w[c] = vin[c];
      if (vin[c] < V_MIN)      vc_w[c] = V_MIN;
      else if (vin[c] > V_MAX) vc_w[c] = V_MAX;
      ic_w[c]    = vc_w[c] / R;
      cap_tgt[c] = ic_w[c];
      if (ic_w[c] < I_MIN)      cap_tgt[c] = I_MIN;
      else if (ic_w[c] > I_MAX) cap_tgt[c] = I_MAX;
      cap_sat[c] = (vin[c] < V_MIN) || (vin[c] > V_MAX) || (ic_w[c] < I_MIN) || (ic_w[c] > I_MAX);
      cap_cnt[c] = cap_sat[c] ? cnt_q[c] + CW'(1) : '0;
      cap_hit[c] = cap_sat[c] && (cap_cnt[c] >= CW'(SAT_LIMIT));

      diff_w[c]    = tgt_q[c] - iout_q[c];
      ramp_done[c] = (diff_w[c] <= STEP_TOL) && (diff_w[c] >= -STEP_TOL);
      if (ramp_done[c])        ramp_w[c] = tgt_q[c];
      else if (diff_w[c] > 0.0) ramp_w[c] = iout_q[c] + I_STEP;
      else                      ramp_w[c] = iout_q[c] - I_STEP;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < N_CH; c++) begin
        state_q[c] <= ST_OFF;
        iout_q[c]  <= 0.0;
        tgt_q[c]   <= 0.0;
        cnt_q[c]   <= '0;
      end
      sat_q <= '0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        state_q[c] <= state_d[c];
        iout_q[c]  <= iout_d[c];
        tgt_q[c]   <= tgt_d[c];
        cnt_q[c]   <= cnt_d[c];
      end
      sat_q <= sat_d;
    end
  end

  // Next state. Within IDLE the order encodes: fault entry > en=0 > capture.
  // fault_clr is only looked at in FAULT, so it outranks everything that state sees.
  always_comb begin
    sat_d = sat_q;
    for (int c = 0; c < N_CH; c++) begin
      state_d[c] = state_q[c];
      iout_d[c]  = iout_q[c];
      tgt_d[c]   = tgt_q[c];
      cnt_d[c]   = cnt_q[c];
      case (state_q[c])
        ST_OFF: begin
          iout_d[c] = 0.0;
          tgt_d[c]  = 0.0;
          if (en[c]) state_d[c] = ST_IDLE;
        end
        ST_IDLE: begin
          if (cap && cap_hit[c]) begin
            state_d[c] = ST_FAULT;
            iout_d[c]  = 0.0;
            tgt_d[c]   = 0.0;
            sat_d[c]   = 1'b1;
            cnt_d[c]   = cap_cnt[c];
          end else if (!en[c]) begin
            state_d[c] = ST_OFF;
            iout_d[c]  = 0.0;
            tgt_d[c]   = 0.0;
          end else if (cap) begin
            tgt_d[c] = cap_tgt[c];
            sat_d[c] = cap_sat[c];
            cnt_d[c] = cap_cnt[c];
            if (cap_tgt[c] != iout_q[c]) state_d[c] = ST_SLEW;
          end
        end
        ST_SLEW: begin
          if (!en[c]) begin
            state_d[c] = ST_OFF;
            iout_d[c]  = 0.0;
            tgt_d[c]   = 0.0;
          end else begin
            iout_d[c] = ramp_w[c];
            if (ramp_done[c]) state_d[c] = ST_IDLE;
          end
        end
        ST_FAULT: begin
          iout_d[c] = 0.0;
          tgt_d[c]  = 0.0;
          if (fault_clr[c]) begin
            cnt_d[c]   = '0;
            sat_d[c]   = 1'b0;
            state_d[c] = en[c] ? ST_IDLE : ST_OFF;
          end
        end
        default: state_d[c] = ST_OFF;
      endcase
    end
  end

  always_comb begin
    in_ready = 1'b1;
    settled  = '0;
    fault    = '0;
    sat      = sat_q;
    for (int c = 0; c < N_CH; c++) begin
      iout[c]    = iout_q[c];
      if (state_q[c] == ST_SLEW) in_ready = 1'b0;
      settled[c] = (state_q[c] == ST_IDLE) && (iout_q[c] == tgt_q[c]);
      fault[c]   = (state_q[c] == ST_FAULT);
    end
  end

endmodule

// File: tb/tb_v2i_slew_mc.sv
// tb_v2i_slew_mc: directed + randomized check of v2i_slew_mc against a closed-form ramp model.
// Latency: outputs are compared 1 time unit after every rising edge.
// Backpressure: the model decides capture from its own view of whether any channel is still ramping.
module tb_v2i_slew_mc;
  localparam int  NC        = 4;
  localparam real R         = 1000.0;
  localparam real V_MIN     = -5.0;
  localparam real V_MAX     = 5.0;
  localparam real I_MIN     = -10.0e-3;
  localparam real I_MAX     = 10.0e-3;
  localparam real I_STEP    = 1.0e-4;
  localparam int  SAT_LIMIT = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  real           vin [NC];
  logic          in_valid;
  logic          in_ready;
  logic [NC-1:0] en, fault_clr, settled, sat, fault;
  real           iout [NC];

  always #5 clk = ~clk;

  v2i_slew_mc #(
    .N_CH(NC), .R(R), .V_MIN(V_MIN), .V_MAX(V_MAX), .I_MIN(I_MIN), .I_MAX(I_MAX),
    .I_STEP(I_STEP), .SAT_LIMIT(SAT_LIMIT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .vin(vin), .in_valid(in_valid), .in_ready(in_ready),
    .en(en), .fault_clr(fault_clr), .iout(iout), .settled(settled), .sat(sat), .fault(fault)
  );

  int nvec = 0;
  int nmis = 0;

  // Reference model: each ramp is described by its start current, target,
  // length in edges and edges elapsed; the current follows in closed form.
  bit  m_on  [NC];
  bit  m_flt [NC];
  bit  m_sat [NC];
  int  m_cnt [NC];
  int  m_len [NC];
  int  m_t   [NC];
  real m_i0  [NC];
  real m_tgt [NC];

  function automatic real exp_i(int c);
    if (m_t[c] >= m_len[c]) return m_tgt[c];
    if (m_tgt[c] > m_i0[c]) return m_i0[c] + real'(m_t[c]) * I_STEP;
    return m_i0[c] - real'(m_t[c]) * I_STEP;
  endfunction

  function automatic bit slewing(int c);
    return m_on[c] && !m_flt[c] && (m_t[c] < m_len[c]);
  endfunction

  function automatic bit any_slew();
    for (int c = 0; c < NC; c++) if (slewing(c)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic real ref_tgt(real v, output bit s);
    real vc, ic;
    vc = (v < V_MIN) ? V_MIN : (v > V_MAX) ? V_MAX : v;
    ic = vc / R;
    s  = (v < V_MIN) || (v > V_MAX) || (ic < I_MIN) || (ic > I_MAX);
    return (ic < I_MIN) ? I_MIN : (ic > I_MAX) ? I_MAX : ic;
  endfunction

  task automatic zero_ch(int c);
    m_i0[c] = 0.0; m_tgt[c] = 0.0; m_t[c] = 0; m_len[c] = 0;
  endtask

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      m_on[c] = 0; m_flt[c] = 0; m_sat[c] = 0; m_cnt[c] = 0;
      zero_ch(c);
    end
  endtask

  // Apply one rising edge to the model using the inputs currently driven.
  task automatic model_edge();
    bit  capture, s;
    real t, d;
    int  n;
    capture = in_valid && !any_slew();
    for (int c = 0; c < NC; c++) begin
      t = ref_tgt(vin[c], s);
      n = s ? m_cnt[c] + 1 : 0;
      if (m_flt[c]) begin
        if (fault_clr[c]) begin
          m_flt[c] = 0; m_cnt[c] = 0; m_sat[c] = 0; m_on[c] = en[c];
        end
        continue;
      end
      if (m_on[c] && !slewing(c) && capture && s && n >= SAT_LIMIT) begin
        m_flt[c] = 1; m_on[c] = 0; m_sat[c] = 1; m_cnt[c] = n;
        zero_ch(c);
        continue;
      end
      if (!en[c]) begin
        m_on[c] = 0;
        zero_ch(c);
        continue;
      end
      if (!m_on[c]) begin
        m_on[c] = 1;
        continue;
      end
      if (slewing(c)) begin
        m_t[c]++;
      end else if (capture) begin
        m_i0[c]  = exp_i(c);
        m_tgt[c] = t;
        m_t[c]   = 0;
        d = t - m_i0[c];
        if (d < 0.0) d = -d;
        m_len[c] = int'($ceil(d / I_STEP - 1.0e-6));
        m_sat[c] = s;
        m_cnt[c] = n;
      end
    end
  endtask

  task automatic chk_bit(string tag, logic obs, logic expv);
    nvec++;
    assert (obs === expv) else begin
      nmis++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  task automatic chk_real(string tag, real obs, real expv);
    real  d;
    logic ok;
    d  = obs - expv;
    ok = (d <= 1.0e-12) && (d >= -1.0e-12);
    nvec++;
    assert (ok === 1'b1) else begin
      nmis++;
      $error("FAIL %s: observed %g expected %g", tag, obs, expv);
    end
  endtask

  task automatic check_all();
    for (int c = 0; c < NC; c++) begin
      chk_real($sformatf("iout%0d", c), iout[c], (m_on[c] && !m_flt[c]) ? exp_i(c) : 0.0);
      chk_bit($sformatf("settled%0d", c), settled[c], m_on[c] && !m_flt[c] && !slewing(c));
      chk_bit($sformatf("sat%0d", c), sat[c], m_sat[c]);
      chk_bit($sformatf("fault%0d", c), fault[c], m_flt[c]);
    end
    chk_bit("in_ready", in_ready, !any_slew());
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic run_until_ready(int budget);
    int k;
    k = 0;
    while (any_slew() && k < budget) begin
      step();
      k++;
    end
    chk_bit("settle_budget", in_ready, 1'b1);
  endtask

  initial begin
    int k, j;
    rst_n = 1'b0; in_valid = 1'b0; en = '0; fault_clr = '0;
    for (int c = 0; c < NC; c++) vin[c] = 0.0;
    model_reset();
    #2;
    check_all();                       // reset state before any edge
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    en    = '1;
    step();                            // OFF -> IDLE on every channel

    // ch0: 0.5 V -> 5e-4 A in five whole steps
    vin[0] = 0.5; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk_bit("ch0_busy", in_ready, 1'b0);
    repeat (5) step();
    chk_real("ch0_final", iout[0], 5.0e-4);
    chk_bit("ch0_settled", settled[0], 1'b1);

    // ch1: clamped capture, then a descending ramp ending on a half step
    vin[1] = 7.0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk_bit("ch1_sat_hi", sat[1], 1'b1);
    run_until_ready(80);
    chk_real("ch1_tgt_hi", iout[1], 5.0e-3);
    vin[1] = -0.35; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk_bit("ch1_sat_clear", sat[1], 1'b0);
    run_until_ready(80);
    chk_real("ch1_tgt_neg", iout[1], -3.5e-4);

    // ch2: hold a saturated input until SAT_LIMIT captures latch the fault
    vin[2] = 9.0; in_valid = 1'b1;
    k = 0;
    while (!m_flt[2] && k < 400) begin
      step();
      k++;
    end
    chk_bit("ch2_fault", fault[2], 1'b1);
    chk_real("ch2_iout_zero", iout[2], 0.0);

    // clear and a saturated capture in the same cycle: the clear wins
    fault_clr = 4'b0100;
    step();
    fault_clr = '0;
    chk_bit("clr_wins_fault", fault[2], 1'b0);
    chk_bit("clr_wins_sat", sat[2], 1'b0);
    step();                            // one saturated capture, count restarted at 1
    in_valid = 1'b0;
    chk_bit("ch2_resat", sat[2], 1'b1);
    chk_bit("ch2_no_refault", fault[2], 1'b0);
    run_until_ready(80);

    // drop en[3] mid-ramp while ch2 keeps slewing
    vin[0] = 0.0; vin[2] = 1.0; vin[3] = 2.0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (8) step();
    en[3] = 1'b0;
    step();
    chk_real("ch3_off", iout[3], 0.0);
    chk_bit("others_slew", in_ready, 1'b0);
    en[3] = 1'b1;
    step();
    run_until_ready(100);

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      for (int c = 0; c < NC; c++) vin[c] = (real'($urandom_range(0, 2400)) - 1200.0) / 100.0;
      in_valid = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) begin
        j = int'($urandom_range(0, NC - 1));
        en[j] = ~en[j];
      end
      fault_clr = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : '0;
      step();
    end

    // asynchronous reset landing mid-ramp
    in_valid = 1'b0; en = '1; fault_clr = '1;
    step();
    fault_clr = '0;
    run_until_ready(400);
    for (int c = 0; c < NC; c++) vin[c] = 0.0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    run_until_ready(400);
    vin[0] = 4.0; vin[1] = -4.0; vin[2] = 2.5; vin[3] = -2.5; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (5) step();
    chk_bit("pre_rst_busy", in_ready, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk_real("async_rst_ch0", iout[0], 0.0);
    #3;
    rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
